// File: rtl/cache_fill_fsm_if.sv
// Miss/fill bundle between the cache controllers, main memory and the fill FSM.
// master is the fill FSM side; slave is the caches-plus-memory side.
interface cache_fill_fsm_if #(
    parameter int ADDR_W = 16
);
    logic              icache_miss;
    logic [ADDR_W-1:0] icache_miss_addr;
    logic              dcache_miss;
    logic [ADDR_W-1:0] dcache_miss_addr;
    logic              mem_data_valid;
    logic [15:0]       mem_data;
    logic              mem_enable;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] fill_address;
    logic [15:0]       fill_data;
    logic              fill_data_write;
    logic              fill_tag_write;
    logic              ifix;
    logic              dfix;
    logic              fsm_busy;

    modport master (
        input  icache_miss,
        input  icache_miss_addr,
        input  dcache_miss,
        input  dcache_miss_addr,
        input  mem_data_valid,
        input  mem_data,
        output mem_enable,
        output mem_addr,
        output fill_address,
        output fill_data,
        output fill_data_write,
        output fill_tag_write,
        output ifix,
        output dfix,
        output fsm_busy
    );

    modport slave (
        output icache_miss,
        output icache_miss_addr,
        output dcache_miss,
        output dcache_miss_addr,
        output mem_data_valid,
        output mem_data,
        input  mem_enable,
        input  mem_addr,
        input  fill_address,
        input  fill_data,
        input  fill_data_write,
        input  fill_tag_write,
        input  ifix,
        input  dfix,
        input  fsm_busy
    );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: streams one block from memory into the I- or D-cache,
// D-cache first, one fill at a time, requests and responses overlapping.
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 16
) (
    input logic             clk,
    input logic             rst_n,
    cache_fill_fsm_if.master bus
);
    localparam int OFF_W = $clog2(2 * BLOCK_WORDS);
    localparam int CNT_W = $clog2(BLOCK_WORDS) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]  rcv_cnt_q, rcv_cnt_d;
    logic              dtgt_q, dtgt_d;

    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

    // Base is block aligned and idx < BLOCK_WORDS, so this never carries out of the block.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  idx);
        return base + ADDR_W'({idx, 1'b0});
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            req_cnt_q <= '0;
            rcv_cnt_q <= '0;
            dtgt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            req_cnt_q <= req_cnt_d;
            rcv_cnt_q <= rcv_cnt_d;
            dtgt_q    <= dtgt_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        base_d              = base_q;
        req_cnt_d           = req_cnt_q;
        rcv_cnt_d           = rcv_cnt_q;
        dtgt_d              = dtgt_q;
        bus.mem_enable      = 1'b0;
        bus.mem_addr        = '0;
        bus.fill_address    = '0;
        bus.fill_data       = '0;
        bus.fill_data_write = 1'b0;
        bus.fill_tag_write  = 1'b0;
        bus.ifix            = 1'b0;
        bus.dfix            = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.dcache_miss) begin
                    base_d    = block_base(bus.dcache_miss_addr);
                    dtgt_d    = 1'b1;
                    req_cnt_d = '0;
                    rcv_cnt_d = '0;
                    state_d   = FILL;
                end else if (bus.icache_miss) begin
                    base_d    = block_base(bus.icache_miss_addr);
                    dtgt_d    = 1'b0;
                    req_cnt_d = '0;
                    rcv_cnt_d = '0;
                    state_d   = FILL;
                end
            end

            FILL: begin
                bus.dfix = dtgt_q;
                bus.ifix = !dtgt_q;
                if (req_cnt_q < CNT_FULL) begin
                    bus.mem_enable = 1'b1;
                    bus.mem_addr   = word_addr(base_q, req_cnt_q);
                    req_cnt_d      = req_cnt_q + 1'b1;
                end
                // Responses come back in request order, so rcv_cnt alone names the word.
                if (bus.mem_data_valid && (rcv_cnt_q < CNT_FULL)) begin
                    bus.fill_data_write = 1'b1;
                    bus.fill_data       = bus.mem_data;
                    bus.fill_address    = word_addr(base_q, rcv_cnt_q);
                    rcv_cnt_d           = rcv_cnt_q + 1'b1;
                    if (rcv_cnt_q == CNT_LAST) begin
                        bus.fill_tag_write = 1'b1;
                        state_d            = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.fsm_busy = (state_q != IDLE);
endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Miss-handling state machine that services instruction-cache and data-cache misses by streaming a full block from main memory into the missing cache. It drives the fill-side controls of each cache controller: the miss-fixing select, the fill address, fill data, the data-write strobe and the tag-write strobe. It also drives the request side of the multi-cycle memory. One fill is in progress at a time. The data cache has priority over the instruction cache.

Parameters:
BLOCK_WORDS, 8, 16-bit words per cache block; power of two; block size in bytes = 2*BLOCK_WORDS.
ADDR_W, 16, byte address width.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
icache_miss  input  1  instruction cache reports a miss; held until the block is filled
icache_miss_addr  input  ADDR_W  byte address that missed in the I-cache
dcache_miss  input  1  data cache reports a miss; held until the block is filled
dcache_miss_addr  input  ADDR_W  byte address that missed in the D-cache
mem_data_valid  input  1  memory returns one word this cycle; responses return in request order
mem_data  input  16  returned word
mem_enable  output  1  read request to memory this cycle
mem_addr  output  ADDR_W  request byte address
fill_address  output  ADDR_W  cache address for the current fill write
fill_data  output  16  word to write into the cache
fill_data_write  output  1  write fill_data at fill_address
fill_tag_write  output  1  write tag/valid for the block; asserted with the last data write
ifix  output  1  I-cache controller selects the fill path
dfix  output  1  D-cache controller selects the fill path
fsm_busy  output  1  high in any state other than IDLE

Behaviour:
- States: IDLE, FILL, DONE. All state is registered. Reset forces IDLE, clears the counters, and drives every output to 0 immediately. Reset is asynchronous, so this also applies mid-fill. No tag write is ever issued for a block aborted by reset.
- IDLE:
  - If dcache_miss is high, latch base = dcache_miss_addr with the low log2(2*BLOCK_WORDS) bits cleared. Set target=D and go to FILL.
  - Otherwise, if icache_miss is high, do the same with icache_miss_addr and target=I.
  - Otherwise stay in IDLE.
  - mem_data_valid is ignored in IDLE.
- FILL:
  - Two counters run: req_cnt and rcv_cnt, each 0..BLOCK_WORDS.
  - Requests: while req_cnt < BLOCK_WORDS, drive mem_enable=1 and mem_addr = base + 2*req_cnt, then increment req_cnt. One request per cycle; the first request is in the first FILL cycle.
  - Responses: when mem_data_valid is high, drive fill_data_write=1, fill_data=mem_data and fill_address = base + 2*rcv_cnt, then increment rcv_cnt.
  - When mem_data_valid is high and rcv_cnt==BLOCK_WORDS-1, also drive fill_tag_write=1 in the same cycle and go to DONE.
  - Requests and responses can overlap in the same cycle.
  - Response gaps (mem_data_valid low) are allowed; no write is issued on those cycles.
- ifix/dfix: the bit matching target is high for every FILL cycle. Both are low in IDLE and DONE.
- DONE: one cycle with all cache controls low, so the cache sees the refilled block and deasserts its miss. Then return to IDLE.
- Miss inputs are sampled only in IDLE. A miss that deasserts during FILL does not abort the fill.
- Simultaneous I and D misses: D is filled first. The I miss, still held, is accepted in the IDLE cycle after DONE.
- Address arithmetic: base is block-aligned, so base + 2*(BLOCK_WORDS-1) never carries. A miss at 0xFFFF fills 0xFFF0..0xFFFE with no wrap to 0x0000.
- fill_data_write, fill_tag_write and mem_enable are single-cycle pulses per word. Outputs and addresses are 0 whenever their strobe is low.
- Extra mem_data_valid after rcv_cnt reaches BLOCK_WORDS is a protocol error and is ignored.

Test Plan:
- dcache_miss at addr 0x1234, memory latency 4, returns 0xA000+i:
  - mem_addr 0x1230..0x123E on cycles 1-8.
  - fill writes 0x1230..0x123E on cycles 5-12 with data 0xA000..0xA007.
  - fill_tag_write on cycle 12 only.
  - dfix high cycles 1-12, ifix never high.
  - DONE on cycle 13, IDLE on cycle 14.
- icache_miss 0x0040 and dcache_miss 0x8006 on the same cycle:
  - D block 0x8000 is filled first with dfix.
  - I fill of 0x0040 starts the cycle after returning to IDLE, with ifix high.
- Memory returns with gaps (valid pattern 1,0,0,1,1,0,...):
  - Exactly 8 writes, addresses in order, no write on gap cycles.
  - Tag write only on the 8th valid.
- icache_miss at 0xFFFF:
  - Requests 0xFFF0..0xFFFE.
  - Last write at 0xFFFE, no access to 0x0000.
- rst_n pulsed low after 3 fill writes:
  - All outputs go to 0 immediately, with no tag write.
  - A held miss then restarts from word 0, requesting base+0.
- mem_data_valid=1 with data 0xDEAD while in IDLE with no miss -> no fill_data_write, state stays IDLE.
